// File: rtl/stg2id_q.sv
// Decode stage (stage 2): decodes fetched instructions into a DEPTH-entry FIFO drained by a valid/ready handshake.
// One cycle from acceptance to head; ow_ready/ow_valid depend only on the registered count.
`ifndef SIZE_ADDR
`define SIZE_ADDR 16
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif
`ifndef SIZE_OPC
`define SIZE_OPC 6
`endif
`ifndef SIZE_IMM
`define SIZE_IMM 16
`endif
`ifndef SIZE_IMMSR
`define SIZE_IMMSR 8
`endif
`ifndef SIZE_CC
`define SIZE_CC 4
`endif
`ifndef SIZE_GP
`define SIZE_GP 4
`endif
`ifndef SIZE_SR
`define SIZE_SR 4
`endif

`ifndef OPC_INSTR_HI
`define OPC_INSTR_HI   31
`define OPC_INSTR_LO   26
`define CC_INSTR_HI    25
`define CC_INSTR_LO    22
`define TGT_INSTR_HI   21
`define TGT_INSTR_LO   18
`define SRC_INSTR_HI   17
`define SRC_INSTR_LO   14
`define IMM_INSTR_HI   15
`define IMM_INSTR_LO   0
`define IMMSR_INSTR_HI 13
`define IMMSR_INSTR_LO 6
`endif

`ifndef OPC_R_MOV
`define OPC_R_MOV    6'd0
`define OPC_R_ADD    6'd1
`define OPC_R_SUB    6'd2
`define OPC_R_NOT    6'd3
`define OPC_R_AND    6'd4
`define OPC_R_OR     6'd5
`define OPC_R_XOR    6'd6
`define OPC_R_SHL    6'd7
`define OPC_R_SHR    6'd8
`define OPC_R_CMP    6'd9
`define OPC_R_JCC    6'd10
`define OPC_R_BCC    6'd11
`define OPC_R_LD     6'd12
`define OPC_R_ST     6'd13
`define OPC_RS_ADDs  6'd14
`define OPC_RS_SUBs  6'd15
`define OPC_RS_SHRs  6'd16
`define OPC_RS_CMPs  6'd17
`define OPC_I_MOVi   6'd18
`define OPC_I_ADDi   6'd19
`define OPC_I_SUBi   6'd20
`define OPC_I_ANDi   6'd21
`define OPC_I_ORi    6'd22
`define OPC_I_XORi   6'd23
`define OPC_I_SHLi   6'd24
`define OPC_I_SHRi   6'd25
`define OPC_I_CMPi   6'd26
`define OPC_I_JCCi   6'd27
`define OPC_I_LDi    6'd28
`define OPC_I_STi    6'd29
`define OPC_IS_MOVis 6'd30
`define OPC_IS_ADDis 6'd31
`define OPC_IS_SUBis 6'd32
`define OPC_IS_SHRis 6'd33
`define OPC_IS_CMPis 6'd34
`define OPC_IS_BCCis 6'd35
`define OPC_S_SRMOV  6'd36
`define OPC_S_SRJCC  6'd37
`endif

module stg2id_q #(
  parameter int DEPTH       = 2,
  parameter int ZERO_UNUSED = 1
) (
  input  logic                         iw_clk,
  input  logic                         iw_rst,
  input  logic                         iw_flush,
  input  logic                         iw_valid,
  output logic                         ow_ready,
  input  logic [`SIZE_ADDR-1:0]        iw_pc,
  input  logic [`SIZE_DATA-1:0]        iw_instr,
  output logic                         ow_valid,
  input  logic                         iw_ready,
  output logic [`SIZE_ADDR-1:0]        ow_pc,
  output logic [`SIZE_DATA-1:0]        ow_instr,
  output logic [`SIZE_OPC-1:0]         ow_opc,
  output logic                         ow_sgn_en,
  output logic                         ow_imm_en,
  output logic                         ow_is_branch,
  output logic [`SIZE_IMM-1:0]         ow_imm_val,
  output logic [`SIZE_IMMSR-1:0]       ow_immsr_val,
  output logic [`SIZE_CC-1:0]          ow_cc,
  output logic [`SIZE_GP-1:0]          ow_tgt_gp,
  output logic [`SIZE_SR-1:0]          ow_tgt_sr,
  output logic [`SIZE_GP-1:0]          ow_src_gp,
  output logic [`SIZE_SR-1:0]          ow_src_sr,
  output logic [$clog2(DEPTH+1)-1:0]   ow_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam bit KEEP_RAW = (ZERO_UNUSED == 0);

  typedef struct packed {
    logic [`SIZE_ADDR-1:0]  pc;
    logic [`SIZE_DATA-1:0]  instr;
    logic [`SIZE_OPC-1:0]   opc;
    logic                   sgn_en;
    logic                   imm_en;
    logic                   is_branch;
    logic [`SIZE_IMM-1:0]   imm_val;
    logic [`SIZE_IMMSR-1:0] immsr_val;
    logic [`SIZE_CC-1:0]    cc;
    logic [`SIZE_GP-1:0]    tgt_gp;
    logic [`SIZE_SR-1:0]    tgt_sr;
    logic [`SIZE_GP-1:0]    src_gp;
    logic [`SIZE_SR-1:0]    src_sr;
  } rec_t;

  rec_t          dec;
  rec_t          head;
  rec_t          mem_q [DEPTH];
  rec_t          mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;
  logic          sgn, imm, br, v_tgt_gp, v_src_gp, v_tgt_sr, v_src_sr, v_immsr;
  logic [`SIZE_OPC-1:0] opc;

  assign opc = iw_instr[`OPC_INSTR_HI:`OPC_INSTR_LO];

  always_comb begin
    sgn      = 1'b0;
    imm      = 1'b0;
    br       = 1'b0;
    v_tgt_gp = 1'b0;
    v_src_gp = 1'b0;
    v_tgt_sr = 1'b0;
    v_src_sr = 1'b0;
    v_immsr  = 1'b0;
    case (opc)
      `OPC_R_MOV, `OPC_R_ADD, `OPC_R_SUB, `OPC_R_AND, `OPC_R_OR,
      `OPC_R_XOR, `OPC_R_SHL, `OPC_R_SHR, `OPC_R_CMP: begin
        v_tgt_gp = 1'b1;
        v_src_gp = 1'b1;
      end
      `OPC_R_NOT, `OPC_R_LD: v_tgt_gp = 1'b1;
      `OPC_R_JCC, `OPC_R_BCC: begin
        v_src_gp = 1'b1;
        br       = 1'b1;
      end
      `OPC_R_ST: v_src_gp = 1'b1;
      `OPC_RS_ADDs, `OPC_RS_SUBs, `OPC_RS_SHRs, `OPC_RS_CMPs: begin
        v_tgt_gp = 1'b1;
        v_src_gp = 1'b1;
        sgn      = 1'b1;
      end
      `OPC_I_MOVi, `OPC_I_ADDi, `OPC_I_SUBi, `OPC_I_ANDi, `OPC_I_ORi,
      `OPC_I_XORi, `OPC_I_SHLi, `OPC_I_SHRi, `OPC_I_CMPi, `OPC_I_LDi: begin
        imm      = 1'b1;
        v_tgt_gp = 1'b1;
      end
      `OPC_I_JCCi: begin
        imm = 1'b1;
        br  = 1'b1;
      end
      `OPC_I_STi: imm = 1'b1;
      `OPC_IS_MOVis, `OPC_IS_ADDis, `OPC_IS_SUBis, `OPC_IS_SHRis, `OPC_IS_CMPis: begin
        imm      = 1'b1;
        sgn      = 1'b1;
        v_tgt_gp = 1'b1;
      end
      `OPC_IS_BCCis: begin
        imm = 1'b1;
        sgn = 1'b1;
        br  = 1'b1;
      end
      `OPC_S_SRMOV: begin
        v_tgt_sr = 1'b1;
        v_src_sr = 1'b1;
      end
      `OPC_S_SRJCC: begin
        v_src_sr = 1'b1;
        v_immsr  = 1'b1;
        br       = 1'b1;
      end
      default: ;
    endcase
  end

  // Field slices overlap in the encoding, so masking is what keeps unused ones clean.
  always_comb begin
    dec           = '0;
    dec.pc        = iw_pc;
    dec.instr     = iw_instr;
    dec.opc       = opc;
    dec.sgn_en    = sgn;
    dec.imm_en    = imm;
    dec.is_branch = br;
    dec.imm_val   = (imm || KEEP_RAW) ? iw_instr[`IMM_INSTR_HI:`IMM_INSTR_LO] : '0;
    dec.immsr_val = (v_immsr || KEEP_RAW) ? iw_instr[`IMMSR_INSTR_HI:`IMMSR_INSTR_LO] : '0;
    dec.cc        = (br || KEEP_RAW) ? iw_instr[`CC_INSTR_HI:`CC_INSTR_LO] : '0;
    dec.tgt_gp    = (v_tgt_gp || KEEP_RAW) ? iw_instr[`TGT_INSTR_HI:`TGT_INSTR_LO] : '0;
    dec.tgt_sr    = (v_tgt_sr || KEEP_RAW) ? iw_instr[`TGT_INSTR_HI:`TGT_INSTR_LO] : '0;
    dec.src_gp    = (v_src_gp || KEEP_RAW) ? iw_instr[`SRC_INSTR_HI:`SRC_INSTR_LO] : '0;
    dec.src_sr    = (v_src_sr || KEEP_RAW) ? iw_instr[`SRC_INSTR_HI:`SRC_INSTR_LO] : '0;
  end

  assign ow_ready = (count_q != CW'(DEPTH));
  assign ow_valid = (count_q != '0);
  assign push     = iw_valid && ow_ready && !iw_flush;
  assign pop      = ow_valid && iw_ready && !iw_flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (iw_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = dec;
  end

  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never reset; an empty FIFO hides it behind the bubble mux below.
  always_ff @(posedge iw_clk) begin
    mem_q <= mem_d;
  end

  assign head = ow_valid ? mem_q[rd_ptr_q] : '0;

  assign ow_pc        = head.pc;
  assign ow_instr     = head.instr;
  assign ow_opc       = head.opc;
  assign ow_sgn_en    = head.sgn_en;
  assign ow_imm_en    = head.imm_en;
  assign ow_is_branch = head.is_branch;
  assign ow_imm_val   = head.imm_val;
  assign ow_immsr_val = head.immsr_val;
  assign ow_cc        = head.cc;
  assign ow_tgt_gp    = head.tgt_gp;
  assign ow_tgt_sr    = head.tgt_sr;
  assign ow_src_gp    = head.src_gp;
  assign ow_src_sr    = head.src_sr;
  assign ow_count     = count_q;

endmodule

// File: tb/tb_stg2id_q.sv
// Directed bench for stg2id_q: instance a is DEPTH=2 masked, instance b is DEPTH=4 unmasked, sharing inputs.
module tb_stg2id_q;

  logic        iw_clk = 1'b0;
  logic        iw_rst = 1'b1;
  logic        iw_flush = 1'b0;
  logic        iw_valid = 1'b0;
  logic        iw_ready = 1'b0;
  logic [15:0] iw_pc = '0;
  logic [31:0] iw_instr = '0;

  logic        rdy_a, vld_a, sgn_a, imm_en_a, br_a;
  logic [15:0] pc_a, imm_a;
  logic [31:0] instr_a;
  logic [5:0]  opc_a;
  logic [7:0]  immsr_a;
  logic [3:0]  cc_a, tgt_gp_a, tgt_sr_a, src_gp_a, src_sr_a;
  logic [1:0]  cnt_a;

  logic        rdy_b, vld_b, sgn_b, imm_en_b, br_b;
  logic [15:0] pc_b, imm_b;
  logic [31:0] instr_b;
  logic [5:0]  opc_b;
  logic [7:0]  immsr_b;
  logic [3:0]  cc_b, tgt_gp_b, tgt_sr_b, src_gp_b, src_sr_b;
  logic [2:0]  cnt_b;

  int checks = 0;
  int fails  = 0;

  always #5 iw_clk = ~iw_clk;

  stg2id_q #(.DEPTH(2), .ZERO_UNUSED(1)) dut (
    .iw_clk(iw_clk), .iw_rst(iw_rst), .iw_flush(iw_flush), .iw_valid(iw_valid),
    .ow_ready(rdy_a), .iw_pc(iw_pc), .iw_instr(iw_instr), .ow_valid(vld_a),
    .iw_ready(iw_ready), .ow_pc(pc_a), .ow_instr(instr_a), .ow_opc(opc_a),
    .ow_sgn_en(sgn_a), .ow_imm_en(imm_en_a), .ow_is_branch(br_a),
    .ow_imm_val(imm_a), .ow_immsr_val(immsr_a), .ow_cc(cc_a),
    .ow_tgt_gp(tgt_gp_a), .ow_tgt_sr(tgt_sr_a), .ow_src_gp(src_gp_a),
    .ow_src_sr(src_sr_a), .ow_count(cnt_a)
  );

  stg2id_q #(.DEPTH(4), .ZERO_UNUSED(0)) dut_raw (
    .iw_clk(iw_clk), .iw_rst(iw_rst), .iw_flush(iw_flush), .iw_valid(iw_valid),
    .ow_ready(rdy_b), .iw_pc(iw_pc), .iw_instr(iw_instr), .ow_valid(vld_b),
    .iw_ready(iw_ready), .ow_pc(pc_b), .ow_instr(instr_b), .ow_opc(opc_b),
    .ow_sgn_en(sgn_b), .ow_imm_en(imm_en_b), .ow_is_branch(br_b),
    .ow_imm_val(imm_b), .ow_immsr_val(immsr_b), .ow_cc(cc_b),
    .ow_tgt_gp(tgt_gp_b), .ow_tgt_sr(tgt_sr_b), .ow_src_gp(src_gp_b),
    .ow_src_sr(src_sr_b), .ow_count(cnt_b)
  );

  // Encoding: opc[31:26] cc[25:22] tgt[21:18] src[17:14] imm[15:0] immsr[13:6]
  function automatic logic [31:0] mk(input logic [5:0] opc, input logic [3:0] cc,
                                     input logic [3:0] tgt, input logic [3:0] src,
                                     input logic [15:0] imm);
    logic [31:0] w;
    w = {opc, cc, tgt, 18'd0};
    w[17:14] = src;
    w[15:0] = w[15:0] | imm;
    return w;
  endfunction

  task automatic tick();
    @(posedge iw_clk);
    #1;
  endtask

  task automatic pulse_reset();
    iw_valid = 1'b0;
    iw_flush = 1'b0;
    iw_ready = 1'b0;
    iw_rst = 1'b1;
    #3;
    iw_rst = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (vld_a !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", vld_a); end
    checks++; if (rdy_a !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", rdy_a); end
    checks++; if (cnt_a !== 2'd0) begin fails++; $display("FAIL reset_count got %0d want 0", cnt_a); end
    checks++; if ({pc_a, instr_a, opc_a} !== '0) begin fails++; $display("FAIL reset_data got %h want 0", {pc_a, instr_a, opc_a}); end
    iw_rst = 1'b0;
  endtask

  task automatic test_movi();
    iw_ready = 1'b1;
    iw_valid = 1'b1;
    iw_pc = 16'h0040;
    iw_instr = mk(6'd18, 4'h0, 4'd3, 4'd0, 16'h005A);
    tick();
    iw_valid = 1'b0;
    checks++; if (vld_a !== 1'b1) begin fails++; $display("FAIL movi_valid got %b want 1", vld_a); end
    checks++; if (opc_a !== 6'd18) begin fails++; $display("FAIL movi_opc got %0d want 18", opc_a); end
    checks++; if ({imm_en_a, sgn_a} !== 2'b10) begin fails++; $display("FAIL movi_flags got %b want 10", {imm_en_a, sgn_a}); end
    checks++; if (imm_a !== 16'h005A) begin fails++; $display("FAIL movi_imm got %h want 005a", imm_a); end
    checks++; if (tgt_gp_a !== 4'd3) begin fails++; $display("FAIL movi_tgt got %0d want 3", tgt_gp_a); end
    checks++; if ({src_gp_a, cc_a} !== 8'h00) begin fails++; $display("FAIL movi_src_cc got %h want 00", {src_gp_a, cc_a}); end
    checks++; if (pc_a !== 16'h0040) begin fails++; $display("FAIL movi_pc got %h want 0040", pc_a); end
    tick();
  endtask

  task automatic test_flags();
    logic [5:0] opcs [5];
    logic [3:0] exp [5];
    opcs = '{6'd1, 6'd15, 6'd31, 6'd27, 6'd35};
    // {sgn_en, imm_en, is_branch, tgt_gp valid}
    exp  = '{4'b0001, 4'b1001, 4'b1101, 4'b0110, 4'b1110};
    iw_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      iw_valid = 1'b1;
      iw_pc = 16'h0050 + 16'(i);
      iw_instr = mk(opcs[i], 4'h0, 4'd6, 4'd0, 16'h0001);
      tick();
      checks++;
      if ({sgn_a, imm_en_a, br_a, tgt_gp_a} !== {exp[i][3:1], (exp[i][0] ? 4'd6 : 4'd0)}) begin
        fails++;
        $display("FAIL flags_opc%0d got %b want %b", opcs[i], {sgn_a, imm_en_a, br_a, tgt_gp_a},
                 {exp[i][3:1], (exp[i][0] ? 4'd6 : 4'd0)});
      end
    end
    iw_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    logic [15:0] got[$];
    int cyc;
    pulse_reset();
    iw_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      iw_valid = 1'b1;
      iw_pc = 16'h0010 + 16'(i);
      iw_instr = mk(6'd1, 4'h0, 4'(i), 4'd2, 16'h0);
      tick();
    end
    checks++; if (cnt_a !== 2'd2) begin fails++; $display("FAIL bp_count got %0d want 2", cnt_a); end
    checks++; if (rdy_a !== 1'b0) begin fails++; $display("FAIL bp_ready got %b want 0", rdy_a); end
    iw_pc = 16'h0012;
    tick();
    checks++; if (cnt_a !== 2'd2) begin fails++; $display("FAIL bp_hold_count got %0d want 2", cnt_a); end
    iw_ready = 1'b1;
    cyc = 0;
    while ((iw_valid || vld_a) && cyc < 20) begin
      if (vld_a) got.push_back(pc_a);
      if (iw_valid && rdy_a) begin
        tick();
        iw_valid = 1'b0;
      end else begin
        tick();
      end
      cyc++;
    end
    checks++; if (got.size() != 3) begin fails++; $display("FAIL bp_drain_size got %0d want 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== 16'h0010 + 16'(i)) begin fails++; $display("FAIL bp_order%0d got %h want %h", i, got[i], 16'h0010 + 16'(i)); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_pc[$];
    logic [31:0] exp_in[$];
    int pushed = 0;
    int popped = 0;
    int cyc = 0;
    int bad = 0;
    int over = 0;
    logic do_push, do_pop;
    pulse_reset();
    while ((pushed < 100 || exp_pc.size() != 0) && cyc < 2000) begin
      iw_valid = (pushed < 100);
      iw_pc = 16'h0100 + 16'(pushed);
      iw_instr = {16'(pushed) ^ 16'h3C3C, 16'(pushed * 7)};
      iw_ready = 1'($urandom_range(0, 1));
      do_push = iw_valid && rdy_a;
      do_pop = vld_a && iw_ready;
      if (do_pop) begin
        if (exp_pc.size() == 0 || pc_a !== exp_pc[0] || instr_a !== exp_in[0]) begin
          bad++;
          if (bad < 4) $display("FAIL stream_pop%0d got %h/%h want %h", popped, pc_a, instr_a,
                                (exp_pc.size() != 0) ? exp_pc[0] : 16'hxxxx);
        end
        if (exp_pc.size() != 0) begin
          void'(exp_pc.pop_front());
          void'(exp_in.pop_front());
        end
        popped++;
      end
      if (do_push) begin
        exp_pc.push_back(iw_pc);
        exp_in.push_back(iw_instr);
        pushed++;
      end
      tick();
      if (cnt_a > 2'd2) over++;
      cyc++;
    end
    iw_valid = 1'b0;
    checks++; if (cyc >= 2000) begin fails++; $display("FAIL stream_timeout got %0d cycles want <2000", cyc); end
    checks++; if (bad != 0) begin fails++; $display("FAIL stream_data got %0d bad pops want 0", bad); end
    checks++; if (popped != 100) begin fails++; $display("FAIL stream_popped got %0d want 100", popped); end
    checks++; if (over != 0) begin fails++; $display("FAIL stream_count_bound got %0d overflows want 0", over); end
  endtask

  task automatic test_flush();
    pulse_reset();
    for (int i = 0; i < 2; i++) begin
      iw_valid = 1'b1;
      iw_pc = 16'h0020 + 16'(i);
      iw_instr = mk(6'd2, 4'h0, 4'd1, 4'd1, 16'h0);
      tick();
    end
    checks++; if (cnt_b !== 3'd2) begin fails++; $display("FAIL flush_pre_count got %0d want 2", cnt_b); end
    iw_pc = 16'h0022;
    iw_flush = 1'b1;
    iw_ready = 1'b1;
    tick();
    iw_flush = 1'b0;
    iw_valid = 1'b0;
    checks++; if ({vld_b, rdy_b, cnt_b} !== 5'b01000) begin fails++; $display("FAIL flush_b_state got %b want 01000", {vld_b, rdy_b, cnt_b}); end
    checks++; if ({pc_b, instr_b, imm_b} !== '0) begin fails++; $display("FAIL flush_b_data got %h want 0", {pc_b, instr_b, imm_b}); end
    checks++; if ({vld_a, rdy_a, cnt_a} !== 4'b0100) begin fails++; $display("FAIL flush_a_state got %b want 0100", {vld_a, rdy_a, cnt_a}); end
    tick();
    checks++; if (cnt_b !== 3'd0) begin fails++; $display("FAIL flush_discard got %0d want 0", cnt_b); end
    iw_ready = 1'b0;
    iw_valid = 1'b1;
    iw_pc = 16'h0023;
    tick();
    iw_valid = 1'b0;
    checks++; if (pc_b !== 16'h0023) begin fails++; $display("FAIL flush_after_pc got %h want 0023", pc_b); end
  endtask

  task automatic test_masking();
    pulse_reset();
    iw_valid = 1'b1;
    iw_pc = 16'h0060;
    iw_instr = mk(6'd10, 4'hA, 4'd5, 4'd7, 16'h0000);
    tick();
    iw_valid = 1'b0;
    checks++; if (tgt_gp_a !== 4'd0) begin fails++; $display("FAIL mask_tgt got %0d want 0", tgt_gp_a); end
    checks++; if ({br_a, cc_a} !== 5'h1A) begin fails++; $display("FAIL mask_br_cc got %h want 1a", {br_a, cc_a}); end
    checks++; if ({src_gp_a, imm_a} !== 20'h70000) begin fails++; $display("FAIL mask_src_imm got %h want 70000", {src_gp_a, imm_a}); end
    checks++; if (tgt_gp_b !== 4'd5) begin fails++; $display("FAIL raw_tgt got %0d want 5", tgt_gp_b); end
    checks++; if ({cc_b, imm_b} !== 20'hAC000) begin fails++; $display("FAIL raw_cc_imm got %h want ac000", {cc_b, imm_b}); end
    iw_ready = 1'b1;
    iw_valid = 1'b1;
    iw_instr = mk(6'd37, 4'h5, 4'd9, 4'd3, 16'h2040);
    tick();
    tick();
    iw_valid = 1'b0;
    checks++;
    if ({tgt_sr_a, src_sr_a, immsr_a, tgt_gp_a, src_gp_a} !== 24'h038100) begin
      fails++;
      $display("FAIL srjcc_fields got %h want 038100", {tgt_sr_a, src_sr_a, immsr_a, tgt_gp_a, src_gp_a});
    end
    checks++; if ({br_a, cc_a, imm_en_a} !== 6'b101010) begin fails++; $display("FAIL srjcc_flags got %b want 101010", {br_a, cc_a, imm_en_a}); end
    tick();
  endtask

  task automatic test_async_reset();
    pulse_reset();
    for (int i = 0; i < 2; i++) begin
      iw_valid = 1'b1;
      iw_pc = 16'h0030 + 16'(i);
      iw_instr = mk(6'd0, 4'h0, 4'd2, 4'd4, 16'h0);
      tick();
    end
    iw_valid = 1'b0;
    checks++; if (cnt_a !== 2'd2) begin fails++; $display("FAIL arst_pre_count got %0d want 2", cnt_a); end
    #3;
    iw_rst = 1'b1;
    #1;
    checks++; if ({vld_a, rdy_a, cnt_a} !== 4'b0100) begin fails++; $display("FAIL arst_state got %b want 0100", {vld_a, rdy_a, cnt_a}); end
    checks++; if ({pc_a, instr_a} !== '0) begin fails++; $display("FAIL arst_data got %h want 0", {pc_a, instr_a}); end
    checks++; if (cnt_b !== 3'd0) begin fails++; $display("FAIL arst_b_count got %0d want 0", cnt_b); end
    #1;
    iw_rst = 1'b0;
    iw_valid = 1'b1;
    iw_pc = 16'h0033;
    tick();
    iw_valid = 1'b0;
    checks++; if ({pc_a, cnt_a} !== {16'h0033, 2'd1}) begin fails++; $display("FAIL arst_first_push got %h/%0d want 0033/1", pc_a, cnt_a); end
  endtask

  initial begin
    test_reset();
    test_movi();
    test_flags();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_masking();
    test_async_reset();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/stg2id_q.md
# stg2id_q

Parametrised decode stage with elastic buffering. Sits between fetch (stage 1) and register read (stage 3). Each accepted instruction is decoded into opcode, sign/immediate enables, condition code and register/SR fields, then stored in a DEPTH-entry FIFO. Downstream consumes it through a valid/ready handshake. Supports pipeline flush and back-pressure, so the fixed single-register decode latch is no longer needed.

## Interface
- DEPTH, 2: FIFO entries. Power of two, 2..16.
- ZERO_UNUSED, 1: 1 = fields unused by the opcode are forced to 0. 0 = raw instruction bit-slices pass through unmasked.
- iw_clk  in  1  clock.
- iw_rst  in  1  reset, asynchronous, active-high.
- iw_flush  in  1  synchronous flush (branch taken / exception).
- iw_valid  in  1  upstream has an instruction.
- ow_ready  out  1  stage can accept (FIFO not full).
- iw_pc  in  `SIZE_ADDR  instruction address.
- iw_instr  in  `SIZE_DATA  instruction word.
- ow_valid  out  1  head entry valid.
- iw_ready  in  1  downstream accepts head.
- ow_pc, ow_instr  out  `SIZE_ADDR, `SIZE_DATA  head copies.
- ow_opc  out  `SIZE_OPC  opcode field.
- ow_sgn_en, ow_imm_en, ow_is_branch  out  1 each  decode flags.
- ow_imm_val, ow_immsr_val, ow_cc  out  `SIZE_IMM, `SIZE_IMMSR, `SIZE_CC  immediate, SR-immediate, condition code.
- ow_tgt_gp, ow_tgt_sr, ow_src_gp, ow_src_sr  out  per sizes.vh  register fields.
- ow_count  out  $clog2(DEPTH+1)  current occupancy.

## Operation
- Decode is combinational on iw_instr. Field positions come from the `*_INSTR_*` bit macros; opcode groups come from the opcodes.vh macros.
  - sgn_en: RS_ADDs, RS_SUBs, RS_SHRs, RS_CMPs, IS_MOVis, IS_ADDis, IS_SUBis, IS_SHRis, IS_CMPis, IS_BCCis.
  - imm_en: all I_* opcodes (MOVi, ADDi, SUBi, ANDi, ORi, XORi, SHLi, SHRi, CMPi, JCCi, LDi, STi) plus all IS_* opcodes.
  - is_branch (cc valid): R_JCC, R_BCC, I_JCCi, IS_BCCis, S_SRJCC.
  - tgt_gp valid:
    - R_MOV, ADD, SUB, NOT, AND, OR, XOR, SHL, SHR, CMP, LD;
    - all RS_*;
    - I_* except JCCi and STi;
    - IS_* except BCCis.
  - src_gp valid:
    - R_MOV, ADD, SUB, AND, OR, XOR, SHL, SHR, CMP, JCC, BCC, ST;
    - all RS_*.
  - tgt_sr valid: S_SRMOV.
  - src_sr valid: S_SRMOV, S_SRJCC.
  - immsr valid: S_SRJCC.
  - Masking: with ZERO_UNUSED=1, an invalid field is 0. imm_val is 0 unless imm_en; cc is 0 unless is_branch.
- Push: iw_valid && ow_ready && !iw_flush. The decoded record plus pc/instr is written at the write pointer.
- Pop: ow_valid && iw_ready && !iw_flush. Advances the read pointer.
- Push and pop in the same cycle: count unchanged, both pointers advance. This is legal at any occupancy where ow_ready=1.
- When full, ow_ready=0. There is no same-cycle pass-through, even if a pop occurs; this keeps ow_ready count-only (no combinational path from iw_ready).
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is tracked in a separate count register.
- Flush clears count and both pointers to 0 and discards the same-cycle push and pop. Storage contents need not be cleared.
- ow_valid = (count != 0). When ow_valid=0, all head data outputs read 0 (bubble), independent of stale storage.

## Timing
- Reset: count=0, pointers=0, ow_valid=0, ow_count=0, ow_ready=1, all data outputs 0.
- Reset asserted mid-stream drops all entries immediately (asynchronous).
- Latency: an instruction accepted at edge N is visible on the outputs after edge N with ow_valid=1, i.e. 1 cycle, the same as the old latch.
- Throughput: 1 instruction/cycle sustained while iw_ready=1.
- ow_ready and ow_valid are functions of registered count only. Data outputs are a mux of registered storage.
- Flush takes effect at the edge where it is sampled: ow_valid=0 and ow_ready=1 in the following cycle.

## Test plan
- Reset, then iw_valid=1, ready=1, I_MOVi with imm 0x5A to tgt r3:
  - ow_valid=1 one cycle later;
  - opc=OPC_I_MOVi, imm_en=1, sgn_en=0, imm_val=0x5A, tgt_gp=3, src_gp=0, cc=0.
- Back-pressure, DEPTH=2: push 3 instructions with iw_ready=0:
  - ow_ready falls after 2 are accepted, ow_count=2;
  - raise iw_ready: the 3 instructions emerge in order with their original pc values (0x10, 0x11, 0x12), nothing lost or duplicated.
- Streaming: 100 back-to-back instructions with iw_ready toggling pseudo-randomly:
  - output sequence equals input sequence;
  - ow_count stays within 0..DEPTH;
  - pointers wrap correctly.
- Flush with FIFO holding 2 entries and a simultaneous push:
  - next cycle ow_valid=0, ow_count=0, data outputs 0;
  - the pushed instruction is discarded.
- Masking: R_JCC with raw tgt bits = 5 and ZERO_UNUSED=1:
  - tgt_gp=0, is_branch=1, cc equals the instr cc field.
  - Repeat with ZERO_UNUSED=0: tgt_gp=5.
- Async reset asserted mid-cycle with 2 entries queued:
  - outputs go to reset values without waiting for a clock edge;
  - the first push after release appears at the head.
